// File: rtl/baccarat_sequencer_if.sv
// Score/card inputs and load/light/done outputs between the baccarat sequencer and its datapath.
// Master is the sequencer side; slave is the datapath side.
interface baccarat_sequencer_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );
endinterface

// File: rtl/baccarat_sequencer.sv
// Moore FSM dealing one baccarat hand: six card strobes in order, third-card rules, win lights; hand ends at c6..c9.
// No backpressure: one state step per slow_clock edge, decisions only from registered datapath scores.
module baccarat_sequencer (
  input  logic                 slow_clock,
  input  logic                 reset,
  baccarat_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, P1, D1, P2, D2, EVAL, P3, DDEC, D3, DONE
  } state_t;

  // load vector bit order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
  state_t     state_q, state_d;
  logic [5:0] load_q, load_d;
  logic       done_q, done_d;

  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] pc);
    logic draw;
    draw = 1'b0;
    case (ds)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pc != 4'd8);
      4'd4:             draw = (pc >= 4'd2) && (pc <= 4'd7);
      4'd5:             draw = (pc >= 4'd4) && (pc <= 4'd7);
      4'd6:             draw = (pc >= 4'd6) && (pc <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = P1;
      P1:   state_d = D1;
      D1:   state_d = P2;
      P2:   state_d = D2;
      D2:   state_d = EVAL;
      EVAL: begin
        if ((bus.pscore >= 4'd8) || (bus.dscore >= 4'd8)) state_d = DONE;
        else if (bus.pscore <= 4'd5)                      state_d = P3;
        else if (bus.dscore <= 4'd5)                      state_d = D3;
        else                                              state_d = DONE;
      end
      P3:   state_d = DDEC;
      DDEC: state_d = dealer_draws(bus.dscore, bus.pcard3) ? D3 : DONE;
      D3:   state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so they line up with the state itself.
  always_comb begin
    load_d = 6'b000000;
    case (state_d)
      P1:      load_d = 6'b100000;
      D1:      load_d = 6'b010000;
      P2:      load_d = 6'b001000;
      D2:      load_d = 6'b000100;
      P3:      load_d = 6'b000010;
      D3:      load_d = 6'b000001;
      default: load_d = 6'b000000;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= IDLE;
      load_q  <= 6'b000000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_pcard1 = load_q[5];
  assign bus.load_dcard1 = load_q[4];
  assign bus.load_pcard2 = load_q[3];
  assign bus.load_dcard2 = load_q[2];
  assign bus.load_pcard3 = load_q[1];
  assign bus.load_dcard3 = load_q[0];
  assign bus.done        = done_q;

  // Lights follow the live scores once the hand is over.
  assign bus.player_win_light = done_q && (bus.pscore >= bus.dscore);
  assign bus.dealer_win_light = done_q && (bus.dscore >= bus.pscore);

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Bench for baccarat_sequencer: directed hands from the test plan plus random hands against a rule-level model.
module tb_baccarat_sequencer;
  logic slow_clock = 1'b0;
  logic reset = 1'b1;
  baccarat_sequencer_if bus ();

  baccarat_sequencer dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus.master)
  );

  always #5 slow_clock = ~slow_clock;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] L_NONE = 6'b000000;
  localparam logic [5:0] L_P1   = 6'b100000;
  localparam logic [5:0] L_D1   = 6'b010000;
  localparam logic [5:0] L_P2   = 6'b001000;
  localparam logic [5:0] L_D2   = 6'b000100;
  localparam logic [5:0] L_P3   = 6'b000010;
  localparam logic [5:0] L_D3   = 6'b000001;

  function automatic logic [5:0] loads_now();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
            bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  endfunction

  // Dealer third-card table after the player drew: allowed pcard3 range per dealer score.
  function automatic bit dealer_takes(input int ds, input int pc);
    int lo[0:7];
    int hi[0:7];
    lo = '{0, 0, 0, 0, 2, 4, 6, 99};
    hi = '{99, 99, 99, 99, 7, 7, 7, 0};
    if (ds > 7) return 1'b0;
    if (ds == 3) return pc != 8;
    return (pc >= lo[ds]) && (pc <= hi[ds]);
  endfunction

  task automatic test_reset();
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd0;
    reset = 1'b1;
    repeat (2) @(posedge slow_clock);
    #1;
    checks++;
    if (loads_now() !== L_NONE || bus.done !== 1'b0 ||
        bus.player_win_light !== 1'b0 || bus.dealer_win_light !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got loads=%b done=%b pl=%b dl=%b exp all 0",
               loads_now(), bus.done, bus.player_win_light, bus.dealer_win_light);
    end
  endtask

  // Deals one hand from reset and checks every cycle against a timeline built from the rules.
  task automatic run_hand(input int ps, input int ds, input int pc, input int ds_late, input string name);
    logic [5:0] tl[$];
    bit nat, pd, dd, exp_done;
    logic [5:0] exp_l;
    int cur_ds, late_c;
    bit exp_pl, exp_dl;

    nat = (ps >= 8) || (ds >= 8);
    pd  = !nat && (ps <= 5);
    dd  = pd ? dealer_takes(ds, pc) : (!nat && (ds <= 5));
    tl.push_back(L_NONE);
    tl.push_back(L_P1);
    tl.push_back(L_D1);
    tl.push_back(L_P2);
    tl.push_back(L_D2);
    tl.push_back(L_NONE);
    if (pd) begin
      tl.push_back(L_P3);
      tl.push_back(L_NONE);
    end
    if (dd) tl.push_back(L_D3);
    late_c = tl.size() + 1;

    test_reset();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) begin
        bus.pscore = 4'(ps);
        bus.dscore = 4'(ds);
      end
      if (c == 7) bus.pcard3 = 4'(pc);
      if (c == late_c) bus.dscore = 4'(ds_late);
      #1;
      exp_done = (c >= tl.size());
      exp_l    = exp_done ? L_NONE : tl[c];
      cur_ds   = (c >= late_c) ? ds_late : ((c >= 5) ? ds : 0);
      exp_pl   = exp_done && (ps >= cur_ds);
      exp_dl   = exp_done && (cur_ds >= ps);
      checks++;
      if (loads_now() !== exp_l) begin
        failures++;
        $display("FAIL %s loads c%0d got=%b exp=%b", name, c, loads_now(), exp_l);
      end
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL %s done c%0d got=%b exp=%b", name, c, bus.done, exp_done);
      end
      checks++;
      if (bus.player_win_light !== exp_pl || bus.dealer_win_light !== exp_dl) begin
        failures++;
        $display("FAIL %s lights c%0d got=%b%b exp=%b%b", name, c,
                 bus.player_win_light, bus.dealer_win_light, exp_pl, exp_dl);
      end
      @(posedge slow_clock);
      #1;
    end
  endtask

  task automatic test_natural();
    run_hand(8, 3, 0, 3, "natural");
  endtask

  task automatic test_player_stands();
    run_hand(7, 4, 0, 7, "stand_dealer_draws_tie");
  endtask

  task automatic test_player_draws();
    run_hand(2, 6, 6, 6, "pdraw_d6_pc6");
    run_hand(2, 6, 5, 6, "pdraw_d6_pc5");
  endtask

  task automatic test_dealer3_boundary();
    run_hand(4, 3, 8, 3, "d3_pc8");
    run_hand(4, 3, 9, 3, "d3_pc9");
  endtask

  task automatic test_reset_mid_hand();
    logic [5:0] exp_seq[0:3];
    exp_seq = '{L_NONE, L_P1, L_D1, L_P2};
    test_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (loads_now() !== exp_seq[c]) begin
        failures++;
        $display("FAIL midreset_pre loads c%0d got=%b exp=%b", c, loads_now(), exp_seq[c]);
      end
      if (c == 3) reset = 1'b1;
      @(posedge slow_clock);
      #1;
    end
    checks++;
    if (loads_now() !== L_NONE || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle got loads=%b done=%b exp loads=000000 done=0", loads_now(), bus.done);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge slow_clock);
      #1;
      checks++;
      if (loads_now() !== exp_seq[c + 1]) begin
        failures++;
        $display("FAIL midreset_restart loads step%0d got=%b exp=%b", c + 1, loads_now(), exp_seq[c + 1]);
      end
    end
  endtask

  task automatic test_random_hands();
    int ps, ds, pc;
    for (int i = 0; i < 40; i++) begin
      ps = (i % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      ds = (i % 5 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      pc = int'($urandom_range(0, 15));
      run_hand(ps, ds, pc, int'($urandom_range(0, 9)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_player_stands();
    test_player_draws();
    test_dealer3_boundary();
    test_reset_mid_hand();
    test_random_hands();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baccarat_sequencer.md
# baccarat_sequencer

Moore state machine that sequences the baccarat card datapath for one hand. It issues the six card-load strobes in dealing order and evaluates the returned scores against the third-card rules. It then drives the win lights. It runs on the same slow clock as the datapath and takes its decisions only from the datapath's registered score and card outputs.

## Interface
- No parameters.
- slow_clock  in  1  single clock; all state and datapath loads advance on its rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- pscore  in  4  player hand score from datapath (0–9)
- dscore  in  4  dealer hand score from datapath (0–9)
- pcard3  in  4  player third-card value from datapath (0 = none, 1–13)
- load_pcard1, load_pcard2, load_pcard3  out  1 each  player card load strobes
- load_dcard1, load_dcard2, load_dcard3  out  1 each  dealer card load strobes
- player_win_light  out  1  player wins (or tie)
- dealer_win_light  out  1  dealer wins (or tie)
- done  out  1  hand complete; held until reset

## Operation
- States: IDLE, P1, D1, P2, D2, EVAL, P3, DDEC, D3, DONE. Encoding is free.
- Outputs are decoded from the state alone:
  - P1 drives load_pcard1.
  - D1 drives load_dcard1.
  - P2 drives load_pcard2.
  - D2 drives load_dcard2.
  - P3 drives load_pcard3.
  - D3 drives load_dcard3.
  - At most one load strobe is high in any cycle.
- Fixed sequence: IDLE→P1→D1→P2→D2→EVAL, unconditionally, one cycle each.
- EVAL decision, evaluated in this priority order:
  - Natural (pscore ≥ 8 or dscore ≥ 8) → DONE.
  - pscore ≤ 5 → P3.
  - Player stands (pscore 6–7) and dscore ≤ 5 → D3.
  - Otherwise → DONE.
- P3→DDEC unconditionally.
- DDEC decision (player drew) goes to D3 when any of these holds, otherwise to DONE:
  - dscore 0–2: draw always.
  - dscore 3: draw if pcard3 ≠ 8.
  - dscore 4: draw if pcard3 in 2–7.
  - dscore 5: draw if pcard3 in 4–7.
  - dscore 6: draw if pcard3 in 6–7.
  - dscore 7: never draw.
- D3→DONE unconditionally.
- DONE is absorbing. It asserts done=1 and drives the lights combinationally from the current scores:
  - player_win_light = (pscore ≥ dscore).
  - dealer_win_light = (dscore ≥ pscore).
  - A tie lights both.
  - Outside DONE, both lights are 0.
- All comparisons are unsigned 4-bit.
- Out-of-range inputs (scores > 9, pcard3 > 13) produce no error. They fall through the rules as their unsigned values; for example, dscore ≥ 8 counts as natural.

## Timing
- Reset (synchronous): the next rising edge with reset=1 puts the block in IDLE.
  - Reset values: all six loads 0, both lights 0, done 0.
  - Reset asserted in any state, including mid-deal, takes effect at that edge.
  - Reset does not clear the datapath; the top level resets it in the same cycle.
- Cycle numbering: c0 is the first cycle after reset deasserts (state IDLE).
  - Then c1 P1, c2 D1, c3 P2, c4 D2, c5 EVAL.
- A card strobe high in cycle cN is captured by the datapath at the end of cN.
  - The resulting score and pcard3 are valid from cN+1.
  - This is why EVAL and DDEC exist as separate decision cycles.
- Hand lengths:
  - Natural, or both stand: DONE at c6.
  - Player stands, dealer draws: D3 c6, DONE c7.
  - Player draws, dealer stands: P3 c6, DDEC c7, DONE c8.
  - Both draw: P3 c6, DDEC c7, D3 c8, DONE c9.
- Lights are only meaningful from the first DONE cycle onward. They track the scores with zero latency.
- There is no enable or handshake: one state step per slow_clock edge.

## Test plan
- Reset check:
  - Stimulus: hold reset 2 cycles, then release.
  - Response: all outputs 0 in reset and c0; load_pcard1, load_dcard1, load_pcard2, load_dcard2 one-hot in c1–c4; no load in c5.
- Natural:
  - Stimulus: pscore=8, dscore=3 at c5.
  - Response: done=1 at c6, player_win_light=1, dealer_win_light=0; load_pcard3 and load_dcard3 never asserted.
- Player stands, dealer draws:
  - Stimulus: pscore=7, dscore=4 at c5.
  - Response: load_dcard3 high at c6, done at c7.
  - Then drive dscore=7: both lights 1 (tie).
- Player draws, dealer rule by pcard3:
  - Stimulus: pscore=2, dscore=6 at c5, pcard3=6 at c7.
  - Response: load_pcard3 at c6, load_dcard3 at c8, done at c9.
  - Repeat with pcard3=5: no load_dcard3, done at c8.
- Dealer 3 boundary:
  - Stimulus: pscore=4, dscore=3, pcard3=8.
  - Response: dealer stands, done at c8.
  - Repeat with pcard3=9: load_dcard3 at c8.
- Reset mid-hand:
  - Stimulus: assert reset during c3 (P2).
  - Response: at c4 the state is IDLE, all loads 0, done 0; after release the deal restarts with load_pcard1 on the second cycle.
